a2bridge_txn_engine: RTL and testbench

// Parametrised transaction engine for the multiplexed bus-bridge CPLD (sel/rd_n/wr_n/d).

---
 rtl/a2bridge_pkg.sv | 35 +++
 rtl/a2bridge_arbiter.sv | 65 ++++++
 rtl/a2bridge_txn_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_a2bridge_txn_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2bridge_pkg.sv
// ---------------------------------------------------------------------------
// a2bridge_pkg
// Shared types and elaboration helpers for the bus-bridge transaction engine.
//   state_e      : bridge cycle sequencing states (IDLE/SETUP/STROBE/HOLD)
//   max3         : largest of three timing values
//   phase_cnt_w  : width of the shared phase counter for a timing set
//   idx_w        : width of a port index for a given requester count
// ---------------------------------------------------------------------------
package a2bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One extra bit of headroom so a count of exactly max timing never wraps.
    function automatic int phase_cnt_w(input int setup_c, input int strobe_c, input int hold_c);
        return $clog2(max3(setup_c, strobe_c, hold_c)) + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a2bridge_arbiter.sv
// ---------------------------------------------------------------------------
// a2bridge_arbiter
// Fixed-priority (lowest index wins) or round-robin arbiter over NUM_REQ
// requesters. Grant is combinational; the round-robin pointer only moves
// when the engine actually takes the grant.
// Ports:
//   clk_logic_i, reset_i : clock, async active-high reset
//   req_i                : per-port request
//   advance_i            : grant consumed this cycle (moves RR pointer)
//   gnt_o                : one-hot grant
//   gnt_idx_o            : binary index of the granted port
//   gnt_valid_o          : some port is granted
// ---------------------------------------------------------------------------
module a2bridge_arbiter
    import a2bridge_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ARB_RR  = 0,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               clk_logic_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    // Port with top priority; stays 0 in fixed-priority mode.
    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int               cand;

    // Scan from the pointer upwards (mod NUM_REQ); first requester wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_valid_o = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else if ((ARB_RR != 0) && advance_i) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            ptr_q <= IDX_W'((int'(gnt_idx_o) + 1) % NUM_REQ);
        end
    end

endmodule

// File: rtl/a2bridge_txn_engine.sv
// ---------------------------------------------------------------------------
// a2bridge_txn_engine
// Transaction engine for the multiplexed bus bridge (sel/rd_n/wr_n/d).
// Arbitrates NUM_REQ requesters, runs each request as a SETUP/STROBE/HOLD
// bridge cycle with programmable phase lengths, routes the completion back
// to the requester, and polls a status select while idle.
// Ports:
//   clk_logic_i, reset_i        : clock, async active-high reset
//   req_valid_i/write/sel/wdata : per-port request (packed per port)
//   req_ready_o                 : one-hot accept pulse (combinational, IDLE only)
//   rsp_valid_o                 : one-hot completion pulse on last HOLD cycle
//   rsp_rdata_o                 : data of the last completed read
//   poll_data_o, poll_valid_o   : last polled status byte and its sample pulse
//   busy_o                      : a bridge cycle is in progress
//   bridge_*                    : bridge pins (sel, strobes, data out/oe/in)
// ---------------------------------------------------------------------------
module a2bridge_txn_engine
    import a2bridge_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SEL_W         = 3,
    parameter int DATA_W        = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1,
    parameter int ARB_RR        = 0,
    parameter int POLL_ENABLE   = 1,
    parameter int POLL_SEL      = 0
) (
    input  logic                      clk_logic_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic [DATA_W-1:0]         poll_data_o,
    output logic                      poll_valid_o,
    output logic                      busy_o,
    output logic [SEL_W-1:0]          bridge_sel_o,
    output logic                      bridge_rd_n_o,
    output logic                      bridge_wr_n_o,
    output logic [DATA_W-1:0]         bridge_d_o,
    output logic                      bridge_d_oe_o,
    input  logic [DATA_W-1:0]         bridge_d_i
);

    localparam int CNT_W = phase_cnt_w(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int IDX_W = idx_w(NUM_REQ);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_PRE    = CNT_W'(HOLD_CYCLES - 2);
    localparam logic [SEL_W-1:0] IDLE_SEL    = SEL_W'(POLL_SEL);

    if (NUM_REQ < 1 || NUM_REQ > 8 || SETUP_CYCLES < 1 || STROBE_CYCLES < 1 ||
        HOLD_CYCLES < 1) begin : g_bad_param
        $error("a2bridge_txn_engine: NUM_REQ must be 1..8 and every phase length >= 1");
    end

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    poll_cnt_q;
    logic                wr_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [SEL_W-1:0]    sel_q;
    logic                rd_n_q;
    logic                wr_n_q;
    logic [DATA_W-1:0]   d_q;
    logic                d_oe_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   poll_data_q;
    logic                poll_valid_q;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_valid;
    logic                take_grant;
    logic                gnt_write;
    logic [SEL_W-1:0]    gnt_sel;
    logic [DATA_W-1:0]   gnt_wdata;

    a2bridge_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ARB_RR  (ARB_RR),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .clk_logic_i (clk_logic_i),
        .reset_i     (reset_i),
        .req_i       (req_valid_i),
        .advance_i   (take_grant),
        .gnt_o       (gnt_oh),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Grants are only honoured in IDLE; elsewhere requesters must hold valid.
    assign take_grant = (state_q == ST_IDLE) && gnt_valid;

    always_comb begin
        gnt_write = req_write_i[gnt_idx];
        gnt_sel   = req_sel_i[int'(gnt_idx)*SEL_W +: SEL_W];
        gnt_wdata = req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    assign req_ready_o   = take_grant ? gnt_oh : '0;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign poll_data_o   = poll_data_q;
    assign poll_valid_o  = poll_valid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign bridge_sel_o  = sel_q;
    assign bridge_rd_n_o = rd_n_q;
    assign bridge_wr_n_o = wr_n_q;
    assign bridge_d_o    = d_q;
    assign bridge_d_oe_o = d_oe_q;

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the strobes and output enable sit behind the async reset
            // so a reset mid-cycle releases the bus immediately; the data
            // registers are reset too since they are few and drive pins.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            poll_cnt_q   <= '0;
            wr_q         <= 1'b0;
            gnt_q        <= '0;
            sel_q        <= '0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            d_q          <= '0;
            d_oe_q       <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            poll_data_q  <= '0;
            poll_valid_q <= 1'b0;
        end else begin
            rsp_valid_q  <= '0;
            poll_valid_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (take_grant) begin
                        // Latch the winner; any in-flight poll is abandoned.
                        state_q    <= ST_SETUP;
                        cnt_q      <= '0;
                        poll_cnt_q <= '0;
                        gnt_q      <= gnt_oh;
                        wr_q       <= gnt_write;
                        sel_q      <= gnt_sel;
                        rd_n_q     <= 1'b1;
                        d_oe_q     <= gnt_write;
                        if (gnt_write) begin
                            d_q <= gnt_wdata;
                        end
                    end else if (POLL_ENABLE != 0) begin
                        sel_q  <= IDLE_SEL;
                        rd_n_q <= 1'b0;
                        // Count only cycles the poll strobe was really low.
                        if (!rd_n_q) begin
                            if (poll_cnt_q == STROBE_LAST) begin
                                poll_cnt_q   <= '0;
                                poll_data_q  <= bridge_d_i;
                                poll_valid_q <= 1'b1;
                            end else begin
                                poll_cnt_q <= poll_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        sel_q  <= IDLE_SEL;
                        rd_n_q <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= '0;
                        rd_n_q  <= wr_q;
                        wr_n_q  <= !wr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        if (!wr_q) begin
                            rsp_rdata_q <= bridge_d_i;
                        end
                        // Completion pulse is registered, so it is armed one
                        // cycle before the last HOLD cycle.
                        if (HOLD_CYCLES == 1) begin
                            rsp_valid_q <= gnt_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        d_oe_q  <= 1'b0;
                        sel_q   <= IDLE_SEL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if ((HOLD_CYCLES >= 2) && (cnt_q == HOLD_PRE)) begin
                            rsp_valid_q <= gnt_q;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2bridge_txn_engine.sv
// ---------------------------------------------------------------------------
// tb_a2bridge_txn_engine
// Directed bench for the bridge transaction engine. Instance A is fixed
// priority with 1/2/1 timing; instance B is the same but round robin.
// Stimulus pushes expected transactions into a queue; a monitor pops and
// compares on every ready/rsp/poll pulse, including bus-pin behaviour
// accumulated over each busy window.
// ---------------------------------------------------------------------------
module tb_a2bridge_txn_engine;

    localparam int NR  = 4;
    localparam int SW  = 3;
    localparam int DW  = 8;
    localparam int SU  = 1;
    localparam int STB = 2;
    localparam int HO  = 1;
    localparam int LAT = SU + STB + HO;

    typedef struct {
        int            port;
        bit            wr;
        logic [SW-1:0] sel;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            t_acc;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A signals
    logic [NR-1:0]    a_valid, a_write, a_ready, a_rsp;
    logic [NR*SW-1:0] a_sel;
    logic [NR*DW-1:0] a_wdata;
    logic [DW-1:0]    a_rdata, a_pdata, a_d_o, a_d_i;
    logic             a_pvalid, a_busy, a_rd_n, a_wr_n, a_oe;
    logic [SW-1:0]    a_bsel;

    // Instance B signals
    logic [NR-1:0]    b_valid, b_write, b_ready, b_rsp;
    logic [NR*SW-1:0] b_sel;
    logic [NR*DW-1:0] b_wdata;
    logic [DW-1:0]    b_rdata, b_pdata, b_d_o, b_d_i;
    logic             b_pvalid, b_busy, b_rd_n, b_wr_n, b_oe;
    logic [SW-1:0]    b_bsel;

    a2bridge_txn_engine #(
        .NUM_REQ(NR), .SEL_W(SW), .DATA_W(DW),
        .SETUP_CYCLES(SU), .STROBE_CYCLES(STB), .HOLD_CYCLES(HO),
        .ARB_RR(0), .POLL_ENABLE(1), .POLL_SEL(0)
    ) dut_a (
        .clk_logic_i(clk), .reset_i(rst),
        .req_valid_i(a_valid), .req_write_i(a_write), .req_sel_i(a_sel),
        .req_wdata_i(a_wdata), .req_ready_o(a_ready), .rsp_valid_o(a_rsp),
        .rsp_rdata_o(a_rdata), .poll_data_o(a_pdata), .poll_valid_o(a_pvalid),
        .busy_o(a_busy), .bridge_sel_o(a_bsel), .bridge_rd_n_o(a_rd_n),
        .bridge_wr_n_o(a_wr_n), .bridge_d_o(a_d_o), .bridge_d_oe_o(a_oe),
        .bridge_d_i(a_d_i)
    );

    a2bridge_txn_engine #(
        .NUM_REQ(NR), .SEL_W(SW), .DATA_W(DW),
        .SETUP_CYCLES(SU), .STROBE_CYCLES(STB), .HOLD_CYCLES(HO),
        .ARB_RR(1), .POLL_ENABLE(1), .POLL_SEL(0)
    ) dut_b (
        .clk_logic_i(clk), .reset_i(rst),
        .req_valid_i(b_valid), .req_write_i(b_write), .req_sel_i(b_sel),
        .req_wdata_i(b_wdata), .req_ready_o(b_ready), .rsp_valid_o(b_rsp),
        .rsp_rdata_o(b_rdata), .poll_data_o(b_pdata), .poll_valid_o(b_pvalid),
        .busy_o(b_busy), .bridge_sel_o(b_bsel), .bridge_rd_n_o(b_rd_n),
        .bridge_wr_n_o(b_wr_n), .bridge_d_o(b_d_o), .bridge_d_oe_o(b_oe),
        .bridge_d_i(b_d_i)
    );

    int total = 0;
    int bad   = 0;

    txn_t exp_q[$];
    txn_t fly_q[$];
    int   rr_exp[$];
    int   rr_seen = 0;
    int   poll_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [NR-1:0] onehot(input int p);
        logic [NR-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // ---------------- Monitor for instance A ----------------
    initial begin : mon_a
        int            cyc;
        int            rd_lo, wr_lo, oe_cnt, sel_bad, d_bad;
        int            last_poll;
        bit            poll_run;
        logic [DW-1:0] d_prev;
        txn_t          t;
        cyc = 0; rd_lo = 0; wr_lo = 0; oe_cnt = 0; sel_bad = 0; d_bad = 0;
        last_poll = 0; poll_run = 1'b0; d_prev = '0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (rst) begin
                poll_run = 1'b0;
                rd_lo = 0; wr_lo = 0; oe_cnt = 0; sel_bad = 0; d_bad = 0;
            end else begin
                // Pin behaviour over the busy window of the in-flight request.
                if (a_busy && fly_q.size() > 0) begin
                    t = fly_q[0];
                    if (!a_rd_n) rd_lo++;
                    if (!a_wr_n) wr_lo++;
                    if (a_oe) begin
                        oe_cnt++;
                        if (a_d_o !== t.wd) d_bad++;
                    end
                    if (a_bsel !== t.sel) sel_bad++;
                end
                if (a_rsp != '0) begin
                    if (fly_q.size() == 0) begin
                        check("unexpected_rsp", a_rsp, '0);
                    end else begin
                        t = fly_q.pop_front();
                        check("rsp_port", a_rsp, onehot(t.port));
                        check("rsp_latency", cyc - t.t_acc, LAT);
                        if (!t.wr) check("rsp_rdata", a_rdata, t.rd);
                        check("rd_n_low_cycles", rd_lo, t.wr ? 0 : STB);
                        check("wr_n_low_cycles", wr_lo, t.wr ? STB : 0);
                        check("d_oe_cycles", oe_cnt, t.wr ? LAT : 0);
                        check("sel_during_txn", sel_bad, 0);
                        check("d_o_during_txn", d_bad, 0);
                    end
                end
                if (a_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", a_ready, '0);
                    end else begin
                        t = exp_q.pop_front();
                        check("grant_port", a_ready, onehot(t.port));
                        t.t_acc = cyc;
                        fly_q.push_back(t);
                    end
                    rd_lo = 0; wr_lo = 0; oe_cnt = 0; sel_bad = 0; d_bad = 0;
                end
                if (a_pvalid) begin
                    poll_seen++;
                    check("poll_data", a_pdata, d_prev);
                    check("poll_pins", {a_rd_n, a_bsel}, {1'b0, 3'd0});
                    if (poll_run) check("poll_spacing", cyc - last_poll, STB);
                    last_poll = cyc;
                    poll_run  = 1'b1;
                end
                if (a_busy) poll_run = 1'b0;
            end
            d_prev = a_d_i;
        end
    end

    // ---------------- Monitor for instance B (grant order) ----------------
    initial begin : mon_b
        forever begin
            @(negedge clk);
            #3;
            if (!rst && b_ready != '0) begin
                if (rr_exp.size() == 0) check("rr_extra_grant", b_ready, '0);
                else check("rr_grant", b_ready, onehot(rr_exp.pop_front()));
                rr_seen++;
            end
        end
    end

    // ---------------- Stimulus helpers (called at a negedge) ----------------
    task automatic exp_push(input int p, input bit wr, input logic [SW-1:0] s,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        txn_t t;
        t.port = p; t.wr = wr; t.sel = s; t.wd = wd; t.rd = rd; t.t_acc = 0;
        exp_q.push_back(t);
    endtask

    task automatic drive(input int p, input bit wr, input logic [SW-1:0] s, input logic [DW-1:0] wd);
        a_write[p]          = wr;
        a_sel[p*SW +: SW]   = s;
        a_wdata[p*DW +: DW] = wd;
        a_valid[p]          = 1'b1;
    endtask

    // Holds valid until ready is seen, then drops it at the following negedge.
    task automatic wait_ready(input int p, input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            #3;
            if (a_ready[p]) got = 1'b1;
            @(negedge clk);
        end
        a_valid[p] = 1'b0;
        if (!got) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (!a_busy && fly_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) timeout(name);
    endtask

    // ---------------- Main sequence ----------------
    initial begin : stim
        bit got;
        int ps;
        rst = 1'b1;
        a_valid = '0; a_write = '0; a_sel = '0; a_wdata = '0; a_d_i = '0;
        b_valid = '0; b_write = '0; b_sel = '0; b_wdata = '0; b_d_i = '0;

        repeat (2) @(negedge clk);
        #3;
        check("reset_outputs",
              {a_bsel, a_rd_n, a_wr_n, a_d_o, a_oe, a_ready, a_rsp, a_rdata, a_pdata, a_pvalid, a_busy},
              {3'd0, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst   = 1'b0;
        a_d_i = 8'hA5;

        // Round robin on B: ports 0,1,3 held valid -> 0,1,3,0.
        rr_exp = '{0, 1, 3, 0};
        b_write = 4'b1011;
        b_valid = 4'b1011;

        // Idle polling on A.
        repeat (12) @(negedge clk);
        #3;
        check("idle_poll_pins", {a_rd_n, a_bsel, a_busy}, {1'b0, 3'd0, 1'b0});
        check("poll_count_idle", poll_seen >= 4, 1'b1);
        check("poll_data_a5", a_pdata, 8'hA5);

        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (rr_seen >= 4) got = 1'b1;
            else @(negedge clk);
        end
        b_valid = '0;
        if (!got) timeout("rr_four_grants");

        // Port 1 read, sel 3, bridge returns 3C.
        @(negedge clk);
        a_d_i = 8'h3C;
        exp_push(1, 1'b0, 3'd3, 8'h00, 8'h3C);
        drive(1, 1'b0, 3'd3, 8'h00);
        wait_ready(1, "read_p1_ready");
        wait_idle("read_p1_done");

        // Port 2 write, sel 1, wdata 7E.
        exp_push(2, 1'b1, 3'd1, 8'h7E, 8'h00);
        drive(2, 1'b1, 3'd1, 8'h7E);
        wait_ready(2, "write_p2_ready");
        wait_idle("write_p2_done");

        // Fixed priority: 0,1,3 valid; port 0 re-requests and re-wins first.
        exp_push(0, 1'b1, 3'd2, 8'h11, 8'h00);
        exp_push(0, 1'b1, 3'd2, 8'h12, 8'h00);
        exp_push(1, 1'b1, 3'd4, 8'h21, 8'h00);
        exp_push(3, 1'b1, 3'd7, 8'h31, 8'h00);
        drive(0, 1'b1, 3'd2, 8'h11);
        drive(1, 1'b1, 3'd4, 8'h21);
        drive(3, 1'b1, 3'd7, 8'h31);
        fork
            begin
                wait_ready(0, "fp_p0_first");
                drive(0, 1'b1, 3'd2, 8'h12);
                wait_ready(0, "fp_p0_second");
            end
            wait_ready(1, "fp_p1");
            wait_ready(3, "fp_p3");
        join
        wait_idle("fp_done");

        // Request lands on the exact poll-sample cycle.
        repeat (4) @(negedge clk);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (a_pvalid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) timeout("poll_sample_wait");
        exp_push(2, 1'b1, 3'd5, 8'h5A, 8'h00);
        drive(2, 1'b1, 3'd5, 8'h5A);
        #3;
        check("collide_ready_and_poll", {a_ready[2], a_pvalid}, 2'b11);
        @(negedge clk);
        a_valid[2] = 1'b0;
        #3;
        check("collide_setup_rd_n_high", {a_busy, a_rd_n}, 2'b11);
        wait_idle("collide_done");

        // Reset during the STROBE phase of a write.
        exp_push(2, 1'b1, 3'd6, 8'hC3, 8'h00);
        drive(2, 1'b1, 3'd6, 8'hC3);
        wait_ready(2, "rst_write_ready");
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            if (!a_wr_n) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) timeout("rst_wait_strobe");
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_strobe", {a_wr_n, a_oe, a_busy, a_rsp}, {1'b1, 1'b0, 1'b0, 4'd0});
        fly_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        ps  = poll_seen;
        repeat (10) @(negedge clk);
        check("post_reset_polls", (poll_seen - ps) >= 3, 1'b1);

        repeat (4) @(negedge clk);
        check("queues_drained", exp_q.size() + fly_q.size() + rr_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
